palindrome: RTL and testbench

//   Registered 3-bit palindrome detector for the word {A,B,C}, with A as the MSB.
//   A word is a palindrome when it reads the same in both directions, i.e. A == C.
//   B is the centre bit and never affects the result.

---
 rtl/palindrome.sv | 51 +++++
 tb/tb_palindrome.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/palindrome.sv
// Registered 3-bit palindrome detector for the word {A,B,C} (A is the MSB).
// A sample is taken on every clock edge where in_valid is high. The registered result follows one cycle later.

module palindrome #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic             F,
  output logic             out_valid,
  output logic [CNT_W-1:0] pal_cnt
);

  // Handshake: no back-pressure. in_valid=1 on an edge means A/B/C are
  // consumed on that edge. out_valid=1 for exactly one cycle per accepted
  // sample, and it marks F as the result of that sample. F keeps its value
  // while out_valid is low.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic is_pal;
  logic cnt_sat;
  logic unused_b;

  // The word reads the same both ways iff its outer bits agree.
  assign is_pal   = ~(A ^ C);
  assign cnt_sat  = (pal_cnt == CNT_MAX);
  assign unused_b = B;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      F         <= 1'b0;
      out_valid <= 1'b0;
      pal_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      // Inputs are only looked at when valid, so X/Z on idle cycles cannot leak in.
      if (in_valid) begin
        F <= is_pal;
        if (is_pal && !cnt_sat) begin
          pal_cnt <= pal_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_palindrome.sv
// Directed bench for palindrome: two instances share stimulus.
// One instance uses the default 8-bit counter; the other uses a 2-bit counter to exercise saturation.

module tb_palindrome;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       a, b, c;
  logic       f8, ov8, f2, ov2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks   = 0;
  int failures = 0;

  // F indexed by {A,B,C}: bit i is the result for word i.
  logic [7:0] f_tab;
  logic [7:0] cnt_tab [8];
  logic       f_first;

  palindrome #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a), .B(b), .C(c),
    .F(f8), .out_valid(ov8), .pal_cnt(cnt8)
  );

  palindrome #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a), .B(b), .C(c),
    .F(f2), .out_valid(ov2), .pal_cnt(cnt2)
  );

  // Clock block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then settle before sampling.
  task automatic drive(input logic r, input logic v, input logic [2:0] abc);
    rst_n    = r;
    in_valid = v;
    {a, b, c} = abc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle_x();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a = 1'bx; b = 1'bz; c = 1'bx;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    f_tab = 8'b1010_0101;
    cnt_tab[0] = 8'd1; cnt_tab[1] = 8'd1; cnt_tab[2] = 8'd2; cnt_tab[3] = 8'd2;
    cnt_tab[4] = 8'd2; cnt_tab[5] = 8'd3; cnt_tab[6] = 8'd3; cnt_tab[7] = 8'd4;

    // Reset held for two clocks while a palindrome is presented.
    drive(1'b0, 1'b1, 3'b101);
    drive(1'b0, 1'b1, 3'b101);
    check("rst_f8",    32'(f8),   32'd0);
    check("rst_ov8",   32'(ov8),  32'd0);
    check("rst_cnt8",  32'(cnt8), 32'd0);
    check("rst_f2",    32'(f2),   32'd0);
    check("rst_cnt2",  32'(cnt2), 32'd0);

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 3'(i));
      check($sformatf("sweep_f_%0d", i),   32'(f8),   32'(f_tab[i]));
      check($sformatf("sweep_ov_%0d", i),  32'(ov8),  32'd1);
      check($sformatf("sweep_cnt_%0d", i), 32'(cnt8), 32'(cnt_tab[i]));
    end
    check("sweep_cnt2_sat", 32'(cnt2), 32'd3);

    // Gap/hold: sample 111, then three idle cycles with undriven word bits.
    drive(1'b1, 1'b1, 3'b111);
    check("gap_f_sample",   32'(f8),   32'd1);
    check("gap_ov_sample",  32'(ov8),  32'd1);
    check("gap_cnt_sample", 32'(cnt8), 32'd5);
    for (int i = 0; i < 3; i++) begin
      drive_idle_x();
      check($sformatf("gap_f_hold_%0d", i),   32'(f8),   32'd1);
      check($sformatf("gap_ov_low_%0d", i),   32'(ov8),  32'd0);
      check($sformatf("gap_cnt_hold_%0d", i), 32'(cnt8), 32'd5);
      check($sformatf("gap_cnt2_hold_%0d", i), 32'(cnt2), 32'd3);
    end

    // Saturation of the 2-bit counter: 1,2,3,3,3 (8-bit one keeps counting).
    drive(1'b0, 1'b0, 3'b000);
    check("sat_rst_cnt2", 32'(cnt2), 32'd0);
    drive(1'b1, 1'b1, 3'b010); check("sat_cnt2_1", 32'(cnt2), 32'd1);
    drive(1'b1, 1'b1, 3'b010); check("sat_cnt2_2", 32'(cnt2), 32'd2);
    drive(1'b1, 1'b1, 3'b010); check("sat_cnt2_3", 32'(cnt2), 32'd3);
    drive(1'b1, 1'b1, 3'b010); check("sat_cnt2_4", 32'(cnt2), 32'd3);
    drive(1'b1, 1'b1, 3'b010); check("sat_cnt2_5", 32'(cnt2), 32'd3);
    check("sat_cnt8_5", 32'(cnt8), 32'd5);
    check("sat_f2",     32'(f2),   32'd1);
    // A non-palindrome at saturation leaves the count alone.
    drive(1'b1, 1'b1, 3'b100);
    check("sat_cnt2_np", 32'(cnt2), 32'd3);
    check("sat_f2_np",   32'(f2),   32'd0);

    // Mid-stream reset during a sweep, with a sample in flight.
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b1, 1'b1, 3'b000);
    drive(1'b1, 1'b1, 3'b001);
    drive(1'b1, 1'b1, 3'b010);
    check("mid_pre_f",   32'(f8),   32'd1);
    check("mid_pre_cnt", 32'(cnt8), 32'd2);
    drive(1'b0, 1'b1, 3'b011);
    check("mid_rst_f",   32'(f8),   32'd0);
    check("mid_rst_ov",  32'(ov8),  32'd0);
    check("mid_rst_cnt", 32'(cnt8), 32'd0);
    drive(1'b1, 1'b1, 3'b101);
    check("mid_post_f",   32'(f8),   32'd1);
    check("mid_post_ov",  32'(ov8),  32'd1);
    check("mid_post_cnt", 32'(cnt8), 32'd1);

    // Centre bit is a don't-care.
    drive(1'b1, 1'b1, 3'b000); f_first = f8;
    drive(1'b1, 1'b1, 3'b010);
    check("ctr_000_f",     32'(f_first), 32'd1);
    check("ctr_000_010",   32'(f8),      32'(f_first));
    drive(1'b1, 1'b1, 3'b101); f_first = f8;
    drive(1'b1, 1'b1, 3'b111);
    check("ctr_101_f",     32'(f_first), 32'd1);
    check("ctr_101_111",   32'(f8),      32'(f_first));
    drive(1'b1, 1'b1, 3'b100); f_first = f8;
    drive(1'b1, 1'b1, 3'b110);
    check("ctr_100_f",     32'(f_first), 32'd0);
    check("ctr_100_110",   32'(f8),      32'(f_first));
    check("ctr_cnt",       32'(cnt8),    32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
